ad9361_tdd_sequencer: RTL and testbench
=======================================

AD9361_TDD_SEQUENCER -- requirements
Module: ad9361_tdd_sequencer

Interface
REQ-001 SHALL have parameter COUNTER_WIDTH, default 24: width of the frame counter and window config fields.
REQ-002 SHALL have parameter GUARD_WIDTH, default 8: width of the guard-time config field.
REQ-003 SHALL have one clock and a reset: axi_aclk, input, 1, sole clock; axi_areset, input, 1, synchronous, active-high.
REQ-004 SHALL have these inputs:
- cfg_enable, 1: run/stop.
- cfg_sync_master, 1: 1 = drive sync, 0 = follow sync.
- cfg_frame_len, COUNTER_WIDTH: frame length in cycles.
- cfg_rx_on and cfg_rx_off, COUNTER_WIDTH each: RX window is cnt in [rx_on, rx_off).
- cfg_tx_on and cfg_tx_off, COUNTER_WIDTH each: TX window is cnt in [tx_on, tx_off).
- cfg_guard, GUARD_WIDTH: guard cycles.
- tdd_sync_i, 1: external sync, asynchronous.
REQ-005 SHALL have these outputs:
- enable, 1: AD9361 ENSM enable pin.
- txnrx, 1: AD9361 ENSM txnrx pin.
- tdd_sync_o, 1: sync pulse out.
- tdd_sync_t, 1: sync tristate, 1 = input.
- rx_active, 1: enable high with txnrx=0.
- tx_active, 1: enable high with txnrx=1.
- cfg_err, 1: configuration error.
- frame_count, 32: completed frames.

Function
REQ-006 SHALL implement a run FSM with states IDLE, ARMED, RUN.
- IDLE->RUN when cfg_enable=1, cfg_frame_len!=0 and cfg_sync_master=1.
- IDLE->ARMED when cfg_enable=1, cfg_frame_len!=0 and cfg_sync_master=0.
- ARMED->RUN on a detected sync rising edge.
- Any state->IDLE when cfg_enable=0.
REQ-007 SHALL pass tdd_sync_i through a 2-flop synchronizer followed by a rising-edge detector; edge detection latency is 3 cycles.
REQ-008 SHALL count cnt 0..cfg_frame_len-1 in RUN, wrap to 0, and increment frame_count at each wrap; frame_count wraps modulo 2^32.
REQ-009 SHALL hold cnt at 0 outside RUN.
REQ-010 SHALL, in follower mode, force cnt to 0 on the cycle after any detected sync edge during RUN; frame_count does not increment on a forced reset.
REQ-011 SHALL, in master mode, pulse tdd_sync_o for 1 cycle on every cycle with cnt==0 in RUN, and drive tdd_sync_t=~cfg_sync_master.
REQ-012 SHALL treat a window with on>=off as empty.
REQ-013 SHALL, when the RX and TX windows overlap at the current cnt, give TX priority and assert cfg_err.
REQ-014 SHALL also assert cfg_err while cfg_enable=1 and cfg_frame_len==0, and SHALL hold the run FSM in IDLE in that case.
REQ-015 SHALL decode the request (NONE/RX/TX) combinationally from the registered cnt, and force it to NONE outside RUN.
REQ-016 SHALL implement a pin FSM with states P_IDLE, P_SETUP, P_ACTIVE, P_RELEASE.
- P_IDLE: on request RX/TX, go to P_SETUP, latch the target direction into txnrx, and load the guard counter with cfg_guard.
- P_SETUP: enable=0; lasts cfg_guard+1 cycles, then goes to P_ACTIVE.
- P_ACTIVE: enable=1; when the request becomes NONE or changes direction, go to P_RELEASE and load the guard counter.
- P_RELEASE: enable=0 with txnrx held; lasts cfg_guard+1 cycles, then goes to P_IDLE.
REQ-017 SHALL decode enable from the registered pin state (enable = state==P_ACTIVE) with no extra register, so latency from a request edge to enable rising is cfg_guard+2 cycles.
REQ-018 SHALL change txnrx only on entry to P_SETUP, and SHALL hold its last value in P_IDLE and P_RELEASE.
REQ-019 SHALL, when cfg_enable drops during P_ACTIVE, complete P_RELEASE before reaching P_IDLE; enable SHALL never remain high after a drop of cfg_enable except during the single cycle in which the drop is sampled.
REQ-020 SHALL sample cfg_guard only on load, so changes mid-count do not affect the count in progress.

Reset
REQ-021 SHALL, on axi_areset=1, clear the run and pin FSMs to IDLE/P_IDLE and clear the synchronizer flops.
REQ-022 SHALL drive these reset values: cnt=0, frame_count=0, enable=0, txnrx=0, tdd_sync_o=0, tdd_sync_t=1, rx_active=0, tx_active=0, cfg_err=0.
REQ-023 SHALL give reset priority over all other inputs, including mid-frame and in P_ACTIVE; enable=0 from the first cycle after reset is sampled.

Verification
REQ-024 SHALL cover basic master mode.
- Setup: master, frame_len=100, rx=[10,50), tx=[60,90), guard=3.
- Required response: txnrx=0 at cnt 11; enable high at cnt 15..50, low at 51; P_IDLE at 55; txnrx=1 at 61; enable high at 65..90; tdd_sync_o pulses at cnt 0; frame_count=2 after 200 RUN cycles.
REQ-025 SHALL cover adjacent windows.
- Setup: rx=[10,50), tx=[50,90), guard=3.
- Required response: enable low at cnt 51..59 (RELEASE 51-54, IDLE 55, SETUP 56-59); txnrx rises at cnt 56; enable high at cnt 60.
REQ-026 SHALL cover follower mode.
- Stimulus: cfg_sync_master=0, tdd_sync_i rising edge at cycle T.
- Required response: RUN with cnt=0 at T+4; tdd_sync_t=1; tdd_sync_o=0 throughout; a second edge mid-frame forces cnt=0 with frame_count unchanged.
REQ-027 SHALL cover a configuration error.
- Stimulus: rx=[10,50), tx=[40,60).
- Required response: cfg_err=1 for cnt 40..49; TX request wins there.
- Stimulus: frame_len=0.
- Required response: cfg_err=1, FSM stays IDLE, enable=0.
REQ-028 SHALL cover a mid-operation stop.
- Stimulus: cfg_enable deasserted during P_ACTIVE with guard=3.
- Required response: enable=0 on the next cycle; P_RELEASE for 4 cycles, then P_IDLE; cnt=0.
REQ-029 SHALL cover reset asserted during P_ACTIVE.
- Required response: all outputs at reset values one cycle later; tdd_sync_t=1.

Source files
------------

// File: rtl/ad9361_tdd_sequencer.sv
// TDD frame sequencer for the AD9361 ENSM pins: a frame counter (master or sync follower)
// decodes RX/TX windows, and a pin FSM inserts guard time around each enable burst.
module ad9361_tdd_sequencer #(
   parameter int unsigned COUNTER_WIDTH = 24,
   parameter int unsigned GUARD_WIDTH   = 8
) (
   input  logic                     axi_aclk,
   input  logic                     axi_areset,
   input  logic                     cfg_enable,
   input  logic                     cfg_sync_master,
   input  logic [COUNTER_WIDTH-1:0] cfg_frame_len,
   input  logic [COUNTER_WIDTH-1:0] cfg_rx_on,
   input  logic [COUNTER_WIDTH-1:0] cfg_rx_off,
   input  logic [COUNTER_WIDTH-1:0] cfg_tx_on,
   input  logic [COUNTER_WIDTH-1:0] cfg_tx_off,
   input  logic [GUARD_WIDTH-1:0]   cfg_guard,
   input  logic                     tdd_sync_i,
   output logic                     enable,
   output logic                     txnrx,
   output logic                     tdd_sync_o,
   output logic                     tdd_sync_t,
   output logic                     rx_active,
   output logic                     tx_active,
   output logic                     cfg_err,
   output logic [31:0]              frame_count
);

   typedef enum logic [1:0] {IDLE, ARMED, RUN} run_state_t;
   typedef enum logic [1:0] {REQ_NONE, REQ_RX, REQ_TX} req_t;
   typedef enum logic [1:0] {P_IDLE, P_SETUP, P_ACTIVE, P_RELEASE} pin_state_t;

   run_state_t               run_state, run_next;
   pin_state_t               pin_state, pin_next;
   req_t                     req;
   logic                     sync_meta, sync_sync, sync_prev, sync_edge;
   logic [COUNTER_WIDTH-1:0] cnt;
   logic [31:0]              frame_cnt;
   logic                     len_err;
   logic                     sync_t_q;
   logic [GUARD_WIDTH-1:0]   guard_cnt;
   logic                     txnrx_q;
   logic                     load_guard, latch_dir;
   logic                     len_ok, running, rx_hit, tx_hit;

   assign len_ok  = (cfg_frame_len != '0);
   assign running = (run_state == RUN);

   always_ff @(posedge axi_aclk) begin
      if (axi_areset) begin
         sync_meta <= 1'b0;
         sync_sync <= 1'b0;
         sync_prev <= 1'b0;
         sync_edge <= 1'b0;
      end else begin
         sync_meta <= tdd_sync_i;
         sync_sync <= sync_meta;
         sync_prev <= sync_sync;
         sync_edge <= sync_sync & ~sync_prev;
      end
   end

   always_ff @(posedge axi_aclk) begin
      if (axi_areset) run_state <= IDLE;
      else            run_state <= run_next;
   end

   always_comb begin
      run_next = run_state;
      case (run_state)
         IDLE:    if (cfg_enable && len_ok) run_next = cfg_sync_master ? RUN : ARMED;
         ARMED:   if (sync_edge) run_next = RUN;
         RUN:     run_next = RUN;
         default: run_next = IDLE;
      endcase
      if (!cfg_enable || !len_ok) run_next = IDLE;
   end

   // A follower resync takes priority over the natural wrap and does not count as a frame.
   always_ff @(posedge axi_aclk) begin
      if (axi_areset) begin
         cnt       <= '0;
         frame_cnt <= '0;
      end else if (running && run_next == RUN) begin
         if (!cfg_sync_master && sync_edge) begin
            cnt <= '0;
         end else if (cnt >= cfg_frame_len - COUNTER_WIDTH'(1)) begin
            cnt       <= '0;
            frame_cnt <= frame_cnt + 32'd1;
         end else begin
            cnt <= cnt + COUNTER_WIDTH'(1);
         end
      end else begin
         cnt <= '0;
      end
   end

   always_ff @(posedge axi_aclk) begin
      if (axi_areset) begin
         len_err  <= 1'b0;
         sync_t_q <= 1'b1;
      end else begin
         len_err  <= cfg_enable && !len_ok;
         sync_t_q <= ~cfg_sync_master;
      end
   end

   // on >= off can never satisfy both bounds, so such a window is empty by construction
   assign rx_hit = (cnt >= cfg_rx_on) && (cnt < cfg_rx_off);
   assign tx_hit = (cnt >= cfg_tx_on) && (cnt < cfg_tx_off);

   always_comb begin
      req = REQ_NONE;
      if (running && cfg_enable) begin
         if (tx_hit)      req = REQ_TX;
         else if (rx_hit) req = REQ_RX;
      end
   end

   always_ff @(posedge axi_aclk) begin
      if (axi_areset) begin
         pin_state <= P_IDLE;
         guard_cnt <= '0;
         txnrx_q   <= 1'b0;
      end else begin
         pin_state <= pin_next;
         if (load_guard)            guard_cnt <= cfg_guard;
         else if (guard_cnt != '0)  guard_cnt <= guard_cnt - GUARD_WIDTH'(1);
         if (latch_dir)             txnrx_q   <= (req == REQ_TX);
      end
   end

   always_comb begin
      pin_next   = pin_state;
      load_guard = 1'b0;
      latch_dir  = 1'b0;
      case (pin_state)
         P_IDLE: begin
            if (req != REQ_NONE) begin
               pin_next   = P_SETUP;
               load_guard = 1'b1;
               latch_dir  = 1'b1;
            end
         end
         P_SETUP:   if (guard_cnt == '0) pin_next = P_ACTIVE;
         P_ACTIVE: begin
            if (req == REQ_NONE || ((req == REQ_TX) != txnrx_q)) begin
               pin_next   = P_RELEASE;
               load_guard = 1'b1;
            end
         end
         P_RELEASE: if (guard_cnt == '0) pin_next = P_IDLE;
         default:   pin_next = P_IDLE;
      endcase
   end

   assign enable      = (pin_state == P_ACTIVE);
   assign txnrx       = txnrx_q;
   assign rx_active   = enable & ~txnrx_q;
   assign tx_active   = enable & txnrx_q;
   assign tdd_sync_o  = running && cfg_sync_master && (cnt == '0);
   assign tdd_sync_t  = sync_t_q;
   assign cfg_err     = (running && rx_hit && tx_hit) || len_err;
   assign frame_count = frame_cnt;

endmodule

// File: tb/tb_ad9361_tdd_sequencer.sv
// Directed bench for ad9361_tdd_sequencer: expectations are queued per cycle and compared after each edge.
module tb_ad9361_tdd_sequencer;

   localparam int unsigned CW = 24;
   localparam int unsigned GW = 8;

   localparam int S_EN  = 0;
   localparam int S_TXN = 1;
   localparam int S_SO  = 2;
   localparam int S_ST  = 3;
   localparam int S_RXA = 4;
   localparam int S_TXA = 5;
   localparam int S_ERR = 6;
   localparam int S_FC  = 7;

   logic          axi_aclk = 1'b0;
   logic          axi_areset;
   logic          cfg_enable, cfg_sync_master;
   logic [CW-1:0] cfg_frame_len, cfg_rx_on, cfg_rx_off, cfg_tx_on, cfg_tx_off;
   logic [GW-1:0] cfg_guard;
   logic          tdd_sync_i;
   logic          enable, txnrx, tdd_sync_o, tdd_sync_t, rx_active, tx_active, cfg_err;
   logic [31:0]   frame_count;

   always #5 axi_aclk = ~axi_aclk;

   ad9361_tdd_sequencer #(
      .COUNTER_WIDTH(CW),
      .GUARD_WIDTH  (GW)
   ) dut (
      .axi_aclk       (axi_aclk),
      .axi_areset     (axi_areset),
      .cfg_enable     (cfg_enable),
      .cfg_sync_master(cfg_sync_master),
      .cfg_frame_len  (cfg_frame_len),
      .cfg_rx_on      (cfg_rx_on),
      .cfg_rx_off     (cfg_rx_off),
      .cfg_tx_on      (cfg_tx_on),
      .cfg_tx_off     (cfg_tx_off),
      .cfg_guard      (cfg_guard),
      .tdd_sync_i     (tdd_sync_i),
      .enable         (enable),
      .txnrx          (txnrx),
      .tdd_sync_o     (tdd_sync_o),
      .tdd_sync_t     (tdd_sync_t),
      .rx_active      (rx_active),
      .tx_active      (tx_active),
      .cfg_err        (cfg_err),
      .frame_count    (frame_count)
   );

   typedef struct {
      int unsigned cycle;
      int          sig;
      logic [31:0] val;
      string       tag;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc    = 0;
   int          checks = 0;
   int          errors = 0;

   function automatic string sig_name(input int sig);
      case (sig)
         S_EN:    return "enable";
         S_TXN:   return "txnrx";
         S_SO:    return "tdd_sync_o";
         S_ST:    return "tdd_sync_t";
         S_RXA:   return "rx_active";
         S_TXA:   return "tx_active";
         S_ERR:   return "cfg_err";
         default: return "frame_count";
      endcase
   endfunction

   function automatic logic [31:0] observe(input int sig);
      case (sig)
         S_EN:    return {31'd0, enable};
         S_TXN:   return {31'd0, txnrx};
         S_SO:    return {31'd0, tdd_sync_o};
         S_ST:    return {31'd0, tdd_sync_t};
         S_RXA:   return {31'd0, rx_active};
         S_TXA:   return {31'd0, tx_active};
         S_ERR:   return {31'd0, cfg_err};
         default: return frame_count;
      endcase
   endfunction

   function automatic void expect_at(input int unsigned c, input int sig,
                                     input logic [31:0] val, input string prefix);
      exp_t e;
      e.cycle = c;
      e.sig   = sig;
      e.val   = val;
      e.tag   = {prefix, ".", sig_name(sig)};
      sb.push_back(e);
   endfunction

   function automatic void push_reset(input int unsigned c, input string prefix);
      expect_at(c, S_EN,  0, prefix);
      expect_at(c, S_TXN, 0, prefix);
      expect_at(c, S_SO,  0, prefix);
      expect_at(c, S_ST,  1, prefix);
      expect_at(c, S_RXA, 0, prefix);
      expect_at(c, S_TXA, 0, prefix);
      expect_at(c, S_ERR, 0, prefix);
      expect_at(c, S_FC,  0, prefix);
   endfunction

   task automatic check_due();
      logic [31:0] obs;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cycle == cyc) begin
            obs = observe(sb[i].sig);
            checks++;
            assert (obs === sb[i].val) else begin
               errors++;
               $error("FAIL %s @cycle %0d: observed %0h expected %0h",
                      sb[i].tag, cyc, obs, sb[i].val);
            end
            sb.delete(i);
         end
      end
   endtask

   task automatic tick();
      @(posedge axi_aclk);
      #1;
      cyc++;
      check_due();
   endtask

   task automatic restart();
      axi_areset = 1'b1;
      tick();
      tick();
      axi_areset = 1'b0;
   endtask

   initial begin
      int unsigned r, cn, t0;
      bit          en, tx;

      axi_areset      = 1'b1;
      cfg_enable      = 1'b1;
      cfg_sync_master = 1'b1;
      cfg_frame_len   = '0;
      cfg_rx_on       = '0;
      cfg_rx_off      = '0;
      cfg_tx_on       = '0;
      cfg_tx_off      = '0;
      cfg_guard       = 8'd3;
      tdd_sync_i      = 1'b0;

      // reset dominates a running, misconfigured request
      for (int unsigned c = 1; c <= 3; c++) push_reset(cyc + c, "reset");
      repeat (3) tick();

      // zero frame length: error flag, no run, no sync pulses
      axi_areset = 1'b0;
      for (int unsigned c = 1; c <= 4; c++) begin
         expect_at(cyc + c, S_ERR, 1, "len0");
         expect_at(cyc + c, S_EN,  0, "len0");
         expect_at(cyc + c, S_SO,  0, "len0");
      end
      expect_at(cyc + 1, S_ST, 0, "len0");
      repeat (4) tick();

      // basic master: rx [10,50), tx [60,90), guard 3, two frames
      cfg_frame_len = 24'd100;
      cfg_rx_on = 24'd10; cfg_rx_off = 24'd50;
      cfg_tx_on = 24'd60; cfg_tx_off = 24'd90;
      r = cyc + 1;
      for (int unsigned c = 0; c <= 200; c++) begin
         cn = c % 100;
         en = (cn >= 15 && cn <= 50) || (cn >= 65 && cn <= 90);
         tx = (c >= 11) && !(cn >= 11 && cn <= 60);
         expect_at(r + c, S_EN,  {31'd0, en}, "master");
         expect_at(r + c, S_TXN, {31'd0, tx}, "master");
         expect_at(r + c, S_SO,  {31'd0, cn == 0}, "master");
         expect_at(r + c, S_RXA, {31'd0, en && !tx}, "master");
         expect_at(r + c, S_TXA, {31'd0, en && tx}, "master");
         expect_at(r + c, S_ERR, 0, "master");
         expect_at(r + c, S_FC,  c / 100, "master");
      end
      while (cyc < r + 200) tick();

      // adjacent windows: rx [10,50), tx [50,90)
      cfg_tx_on = 24'd50;
      restart();
      r = cyc + 1;
      for (int unsigned c = 0; c < 100; c++) begin
         en = (c >= 15 && c <= 50) || (c >= 60 && c <= 90);
         expect_at(r + c, S_EN,  {31'd0, en}, "adjacent");
         expect_at(r + c, S_TXN, {31'd0, c >= 56}, "adjacent");
      end
      while (cyc < r + 99) tick();

      // overlapping windows: rx [10,50), tx [40,60)
      cfg_tx_on = 24'd40; cfg_tx_off = 24'd60;
      restart();
      r = cyc + 1;
      for (int unsigned c = 0; c < 100; c++) begin
         expect_at(r + c, S_ERR, {31'd0, c >= 40 && c <= 49}, "overlap");
         expect_at(r + c, S_EN,  {31'd0, (c >= 15 && c <= 40) || (c >= 50 && c <= 60)}, "overlap");
         expect_at(r + c, S_TXA, {31'd0, c >= 50 && c <= 60}, "overlap");
         expect_at(r + c, S_TXN, {31'd0, c >= 46}, "overlap");
      end
      while (cyc < r + 99) tick();

      // mid-frame stop and restart; tx window has on > off so it stays empty
      cfg_rx_on = 24'd0;  cfg_rx_off = 24'd50;
      cfg_tx_on = 24'd70; cfg_tx_off = 24'd20;
      restart();
      r = cyc + 1;
      for (int unsigned c = 0; c <= 20; c++) begin
         expect_at(r + c, S_EN,  {31'd0, c >= 5}, "stop.pre");
         expect_at(r + c, S_RXA, {31'd0, c >= 5}, "stop.pre");
         expect_at(r + c, S_TXA, 0, "stop.pre");
      end
      while (cyc < r + 20) tick();
      cfg_enable = 1'b0;
      for (int unsigned c = 21; c <= 29; c++) expect_at(r + c, S_EN, 0, "stop.release");
      for (int unsigned c = 30; c <= 35; c++) expect_at(r + c, S_EN, 1, "stop.resume");
      expect_at(r + 30, S_RXA, 1, "stop.resume");
      expect_at(r + 30, S_TXN, 0, "stop.resume");
      expect_at(r + 30, S_FC,  0, "stop.resume");
      expect_at(r + 21, S_SO,  0, "stop.idle");
      expect_at(r + 22, S_SO,  1, "stop.cnt0");
      expect_at(r + 23, S_SO,  0, "stop.cnt1");
      tick();
      cfg_enable = 1'b1;
      while (cyc < r + 27) tick();
      cfg_guard = 8'd7;
      while (cyc < r + 35) tick();

      // reset while the pins are active
      axi_areset = 1'b1;
      push_reset(cyc + 1, "rst_active");
      push_reset(cyc + 2, "rst_active");
      tick();
      tick();

      // follower: arm, start on sync, then resync mid-frame
      cfg_sync_master = 1'b0;
      cfg_guard = 8'd3;
      cfg_rx_on = 24'd10; cfg_rx_off = 24'd50;
      cfg_tx_on = 24'd0;  cfg_tx_off = 24'd0;
      restart();
      for (int unsigned c = 1; c <= 5; c++) begin
         expect_at(cyc + c, S_EN, 0, "armed");
         expect_at(cyc + c, S_SO, 0, "armed");
         expect_at(cyc + c, S_ST, 1, "armed");
      end
      repeat (5) tick();
      t0 = cyc;
      tdd_sync_i = 1'b1;
      for (int unsigned c = 1; c <= 150; c++) expect_at(t0 + c, S_SO, 0, "follow");
      expect_at(t0 + 18,  S_EN,  0, "follow.start");
      expect_at(t0 + 19,  S_EN,  1, "follow.start");
      expect_at(t0 + 19,  S_RXA, 1, "follow.start");
      expect_at(t0 + 19,  S_ST,  1, "follow.start");
      expect_at(t0 + 38,  S_EN,  1, "follow.resync");
      expect_at(t0 + 39,  S_EN,  0, "follow.resync");
      expect_at(t0 + 52,  S_EN,  0, "follow.resync");
      expect_at(t0 + 53,  S_EN,  1, "follow.resync");
      expect_at(t0 + 120, S_FC,  0, "follow.frames");
      expect_at(t0 + 140, S_FC,  1, "follow.frames");
      while (cyc < t0 + 10) tick();
      tdd_sync_i = 1'b0;
      while (cyc < t0 + 34) tick();
      tdd_sync_i = 1'b1;
      while (cyc < t0 + 150) tick();

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL scoreboard_drain: observed %0d pending entries expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
